// File: rtl/acsp_pkg.sv
// Shared types and sizing helpers for the capture/readout datapath.
package acsp_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ARMED,
    POST,
    RD_REQ,
    RD_WAIT,
    SEND,
    WAIT_HI,
    WAIT_LO,
    NEXT
  } capture_state_t;

  localparam int unsigned BYTE_WIDTH = 8;

  function automatic int unsigned bytes_per_sample(input int unsigned sample_width);
    return sample_width / BYTE_WIDTH;
  endfunction

  function automatic int unsigned depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/capture_readout_ctrl_if.sv
// Sample-RAM port plus UART transmit handshake seen by the capture controller.
interface capture_readout_ctrl_if #(
  parameter int unsigned SAMPLE_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH   = 12
) ();

  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [SAMPLE_WIDTH-1:0] mem_wdata;
  logic                    mem_re;
  logic [ADDR_WIDTH-1:0]   mem_raddr;
  logic [SAMPLE_WIDTH-1:0] mem_rdata;
  logic                    tx_busy;
  logic                    tx_start;
  logic [7:0]              tx_byte;

  modport master (
    output mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr, tx_start, tx_byte,
    input  mem_rdata, tx_busy
  );

  modport slave (
    input  mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr, tx_start, tx_byte,
    output mem_rdata, tx_busy
  );

endinterface

// File: rtl/sample_ram.sv
// Simple dual-port sample buffer: one write port, one read port with 1-cycle latency.
module sample_ram
  import acsp_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH   = 12
) (
  input  logic                    clock,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [SAMPLE_WIDTH-1:0] wdata,
  input  logic                    re,
  input  logic [ADDR_WIDTH-1:0]   raddr,
  output logic [SAMPLE_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = depth(ADDR_WIDTH);

  logic [SAMPLE_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/capture_readout_ctrl.sv
// Acquisition sequencer: circular capture, post-trigger fill, then newest-first
// byte-serial readback to the UART transmitter.
module capture_readout_ctrl
  import acsp_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned COUNT_WIDTH  = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    arm,
  input  logic                    abort,
  input  logic                    run,
  input  logic                    valid_in,
  input  logic [SAMPLE_WIDTH-1:0] data_in,
  input  logic [COUNT_WIDTH-1:0]  read_count,
  input  logic [COUNT_WIDTH-1:0]  delay_count,
  capture_readout_ctrl_if.master  bus,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned BYTES = bytes_per_sample(SAMPLE_WIDTH);
  localparam int unsigned DEPTH = depth(ADDR_WIDTH);
  localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  capture_state_t          state;
  logic [ADDR_WIDTH-1:0]   wr_ptr;
  logic [ADDR_WIDTH-1:0]   rd_ptr;
  logic [COUNT_WIDTH-1:0]  delay_q;
  logic [COUNT_WIDTH-1:0]  post_cnt;
  logic [COUNT_WIDTH-1:0]  send_cnt;
  logic [SAMPLE_WIDTH-1:0] shift_q;
  logic [IDX_W-1:0]        byte_idx;
  logic                    wr_en_c;

  // A request longer than the buffer can only return what the buffer holds.
  function automatic logic [COUNT_WIDTH-1:0] clamp_count(input logic [COUNT_WIDTH-1:0] c);
    logic [COUNT_WIDTH-1:0] r;
    r = c;
    if ((ADDR_WIDTH < COUNT_WIDTH) && (32'(c) > DEPTH)) r = COUNT_WIDTH'(DEPTH);
    return r;
  endfunction

  // Writes follow valid_in in the same cycle so no sampler strobe is dropped.
  always_comb begin
    wr_en_c = 1'b0;
    if (!abort) begin
      if (state == ARMED)     wr_en_c = valid_in;
      else if (state == POST) wr_en_c = valid_in && (post_cnt != '0);
    end
  end

  assign bus.mem_we    = wr_en_c;
  assign bus.mem_waddr = wr_ptr;
  assign bus.mem_wdata = wr_en_c ? data_in : '0;
  assign bus.mem_raddr = rd_ptr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      delay_q      <= '0;
      post_cnt     <= '0;
      send_cnt     <= '0;
      shift_q      <= '0;
      byte_idx     <= '0;
      bus.mem_re   <= 1'b0;
      bus.tx_start <= 1'b0;
      bus.tx_byte  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      bus.mem_re   <= 1'b0;
      bus.tx_start <= 1'b0;
      done         <= 1'b0;
      if (wr_en_c) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);

      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (arm) begin
              delay_q  <= delay_count;
              send_cnt <= clamp_count(read_count);
              if (read_count == '0) begin
                done <= 1'b1;
              end else begin
                state <= ARMED;
                busy  <= 1'b1;
              end
            end
          end
          ARMED: begin
            // The sample arriving with the trigger is the first post-trigger sample.
            if (run) begin
              state    <= POST;
              post_cnt <= (valid_in && (delay_q != '0)) ? delay_q - COUNT_WIDTH'(1) : delay_q;
            end
          end
          POST: begin
            if (post_cnt == '0) begin
              state      <= RD_REQ;
              rd_ptr     <= wr_ptr - ADDR_WIDTH'(1);
              bus.mem_re <= 1'b1;
            end else if (valid_in) begin
              post_cnt <= post_cnt - COUNT_WIDTH'(1);
            end
          end
          RD_REQ: begin
            state  <= RD_WAIT;
            rd_ptr <= rd_ptr - ADDR_WIDTH'(1);
          end
          RD_WAIT: begin
            state    <= SEND;
            shift_q  <= bus.mem_rdata;
            byte_idx <= '0;
          end
          SEND: begin
            if (!bus.tx_busy) begin
              state        <= WAIT_HI;
              bus.tx_start <= 1'b1;
              bus.tx_byte  <= shift_q[7:0];
            end
          end
          WAIT_HI: begin
            if (bus.tx_busy) state <= WAIT_LO;
          end
          WAIT_LO: begin
            if (!bus.tx_busy) begin
              if (32'(byte_idx) + 32'd1 < BYTES) begin
                state    <= SEND;
                shift_q  <= shift_q >> 8;
                byte_idx <= byte_idx + IDX_W'(1);
              end else begin
                state <= NEXT;
              end
            end
          end
          NEXT: begin
            send_cnt <= send_cnt - COUNT_WIDTH'(1);
            if (send_cnt == COUNT_WIDTH'(1)) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state      <= RD_REQ;
              bus.mem_re <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_capture_readout_ctrl.sv
// Scoreboard bench: instance A (8-bit samples, 4096 deep), instance B (16-bit samples, 8 deep).
module tb_capture_readout_ctrl;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  logic        arm      [2];
  logic        abort_p  [2];
  logic        run      [2];
  logic        valid_in [2];
  logic [15:0] din      [2];
  logic [15:0] rcnt     [2];
  logic [15:0] dcnt     [2];
  logic        busy     [2];
  logic        done     [2];

  capture_readout_ctrl_if #(.SAMPLE_WIDTH(8),  .ADDR_WIDTH(12)) bus_a ();
  capture_readout_ctrl_if #(.SAMPLE_WIDTH(16), .ADDR_WIDTH(3))  bus_b ();

  capture_readout_ctrl #(.SAMPLE_WIDTH(8), .ADDR_WIDTH(12), .COUNT_WIDTH(16)) dut_a (
    .clock(clock), .reset_n(reset_n), .arm(arm[0]), .abort(abort_p[0]), .run(run[0]),
    .valid_in(valid_in[0]), .data_in(din[0][7:0]), .read_count(rcnt[0]),
    .delay_count(dcnt[0]), .bus(bus_a), .busy(busy[0]), .done(done[0]));

  capture_readout_ctrl #(.SAMPLE_WIDTH(16), .ADDR_WIDTH(3), .COUNT_WIDTH(16)) dut_b (
    .clock(clock), .reset_n(reset_n), .arm(arm[1]), .abort(abort_p[1]), .run(run[1]),
    .valid_in(valid_in[1]), .data_in(din[1]), .read_count(rcnt[1]),
    .delay_count(dcnt[1]), .bus(bus_b), .busy(busy[1]), .done(done[1]));

  sample_ram #(.SAMPLE_WIDTH(8), .ADDR_WIDTH(12)) ram_a (
    .clock(clock), .we(bus_a.mem_we), .waddr(bus_a.mem_waddr), .wdata(bus_a.mem_wdata),
    .re(bus_a.mem_re), .raddr(bus_a.mem_raddr), .rdata(bus_a.mem_rdata));

  sample_ram #(.SAMPLE_WIDTH(16), .ADDR_WIDTH(3)) ram_b (
    .clock(clock), .we(bus_b.mem_we), .waddr(bus_b.mem_waddr), .wdata(bus_b.mem_wdata),
    .re(bus_b.mem_re), .raddr(bus_b.mem_raddr), .rdata(bus_b.mem_rdata));

  // UART model: busy rises the cycle after tx_start and lasts busy_len cycles.
  int busy_len [2];
  int bcnt_a, bcnt_b;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bcnt_a <= 0; bus_a.tx_busy <= 1'b0;
    end else if (bus_a.tx_start) begin
      bcnt_a <= busy_len[0]; bus_a.tx_busy <= 1'b1;
    end else if (bcnt_a > 1) begin
      bcnt_a <= bcnt_a - 1;
    end else begin
      bcnt_a <= 0; bus_a.tx_busy <= 1'b0;
    end
  end

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bcnt_b <= 0; bus_b.tx_busy <= 1'b0;
    end else if (bus_b.tx_start) begin
      bcnt_b <= busy_len[1]; bus_b.tx_busy <= 1'b1;
    end else if (bcnt_b > 1) begin
      bcnt_b <= bcnt_b - 1;
    end else begin
      bcnt_b <= 0; bus_b.tx_busy <= 1'b0;
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Scoreboards: expected bytes and expected done pulses per instance.
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  bit         done_q_a[$];
  bit         done_q_b[$];
  logic [7:0] last_exp_a = 8'h00;
  logic [7:0] last_exp_b = 8'h00;
  int         start_cnt_a = 0;
  int         we_cnt_a = 0;

  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      if (bus_a.mem_we === 1'b1) we_cnt_a++;
      if (bus_a.tx_start === 1'b1) begin
        start_cnt_a++;
        check("a_start_while_busy", int'(bus_a.tx_busy), 0);
        check("a_start_expected", int'(exp_a.size() != 0), 1);
        if (exp_a.size() != 0) begin
          last_exp_a = exp_a.pop_front();
          check("a_tx_byte", int'(bus_a.tx_byte), int'(last_exp_a));
        end
      end
      if (bus_a.tx_busy === 1'b1)
        check("a_tx_byte_stable", int'(bus_a.tx_byte), int'(last_exp_a));
      if (done[0] === 1'b1) begin
        check("a_done_expected", int'(done_q_a.size() != 0), 1);
        check("a_done_after_bytes", exp_a.size(), 0);
        if (done_q_a.size() != 0) void'(done_q_a.pop_front());
      end
    end
  end

  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      if (bus_b.tx_start === 1'b1) begin
        check("b_start_while_busy", int'(bus_b.tx_busy), 0);
        check("b_start_expected", int'(exp_b.size() != 0), 1);
        if (exp_b.size() != 0) begin
          last_exp_b = exp_b.pop_front();
          check("b_tx_byte", int'(bus_b.tx_byte), int'(last_exp_b));
        end
      end
      if (bus_b.tx_busy === 1'b1)
        check("b_tx_byte_stable", int'(bus_b.tx_byte), int'(last_exp_b));
      if (done[1] === 1'b1) begin
        check("b_done_expected", int'(done_q_b.size() != 0), 1);
        check("b_done_after_bytes", exp_b.size(), 0);
        if (done_q_b.size() != 0) void'(done_q_b.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Arm, then stream n consecutive samples first.. with run on index run_at.
  task automatic acq(input int s, input int first, input int n, input int run_at,
                     input int dly, input int rc);
    rcnt[s] = 16'(rc);
    dcnt[s] = 16'(dly);
    arm[s]  = 1'b1;
    tick();
    arm[s]  = 1'b0;
    for (int i = 0; i < n; i++) begin
      valid_in[s] = 1'b1;
      din[s]      = 16'(first + i);
      run[s]      = (i == run_at);
      tick();
    end
    valid_in[s] = 1'b0;
    run[s]      = 1'b0;
  endtask

  task automatic wait_idle(input int s, input string name);
    int k = 0;
    tick();
    while ((busy[s] === 1'b1) && (k < 3000)) begin
      tick();
      k++;
    end
    check({name, "_finished"}, int'(busy[s]), 0);
    repeat (3) tick();
    check({name, "_bytes_left"}, (s == 0) ? exp_a.size() : exp_b.size(), 0);
    check({name, "_done_left"}, (s == 0) ? done_q_a.size() : done_q_b.size(), 0);
  endtask

  task automatic wait_starts(input int target);
    int k = 0;
    while ((start_cnt_a < target) && (k < 500)) begin
      tick();
      k++;
    end
    check("starts_reached", int'(start_cnt_a >= target), 1);
  endtask

  int base;
  int we0;

  initial begin
    reset_n = 1'b1;
    for (int s = 0; s < 2; s++) begin
      arm[s] = 1'b0; abort_p[s] = 1'b0; run[s] = 1'b0; valid_in[s] = 1'b0;
      din[s] = '0; rcnt[s] = '0; dcnt[s] = '0; busy_len[s] = 3;
    end
    #2 reset_n = 1'b0;
    repeat (3) tick();
    check("rst_busy",     int'(busy[0]), 0);
    check("rst_done",     int'(done[0]), 0);
    check("rst_tx_start", int'(bus_a.tx_start), 0);
    check("rst_tx_byte",  int'(bus_a.tx_byte), 0);
    check("rst_mem_re",   int'(bus_a.mem_re), 0);
    check("rst_mem_waddr", int'(bus_a.mem_waddr), 0);
    check("rst_b_busy",   int'(busy[1]), 0);
    reset_n = 1'b1;
    tick();

    // Wrap on an 8-deep buffer: 0x00..0x0A, trigger on the last, read 8 newest.
    busy_len[1] = 2;
    for (int v = 10; v >= 3; v--) begin
      exp_b.push_back(8'(v));
      exp_b.push_back(8'h00);
    end
    done_q_b.push_back(1'b1);
    acq(1, 0, 11, 10, 1, 8);
    wait_idle(1, "wrap");

    // Two-byte sample goes out LSB first.
    busy_len[1] = 4;
    exp_b.push_back(8'hEF);
    exp_b.push_back(8'hBE);
    done_q_b.push_back(1'b1);
    acq(1, 16'hBEEF, 1, 0, 1, 1);
    wait_idle(1, "multibyte");

    // Basic: samples 1..8, trigger with 6, two post samples, read four.
    busy_len[0] = 3;
    exp_a.push_back(8'h07); exp_a.push_back(8'h06);
    exp_a.push_back(8'h05); exp_a.push_back(8'h04);
    done_q_a.push_back(1'b1);
    acq(0, 8'h01, 8, 5, 2, 4);
    wait_idle(0, "counts");

    // Long transmitter busy: one start per byte, byte held steady.
    busy_len[0] = 20;
    base = start_cnt_a;
    exp_a.push_back(8'h14); exp_a.push_back(8'h13); exp_a.push_back(8'h12);
    done_q_a.push_back(1'b1);
    acq(0, 8'h11, 5, 2, 2, 3);
    wait_idle(0, "handshake");
    check("handshake_starts", start_cnt_a - base, 3);

    // Zero read count: done the next cycle, nothing written, never busy.
    busy_len[0] = 3;
    we0 = we_cnt_a;
    done_q_a.push_back(1'b1);
    rcnt[0] = 16'd0; dcnt[0] = 16'd2; arm[0] = 1'b1; valid_in[0] = 1'b1; din[0] = 16'h55;
    tick();
    arm[0] = 1'b0;
    check("zero_done_pulse", int'(done[0]), 1);
    check("zero_busy", int'(busy[0]), 0);
    tick();
    check("zero_done_single", int'(done[0]), 0);
    repeat (2) tick();
    valid_in[0] = 1'b0;
    check("zero_no_writes", we_cnt_a - we0, 0);
    check("zero_done_left", done_q_a.size(), 0);

    // Trigger level while idle does nothing.
    run[0] = 1'b1; valid_in[0] = 1'b1;
    repeat (3) tick();
    check("idle_run_busy", int'(busy[0]), 0);
    run[0] = 1'b0; valid_in[0] = 1'b0;
    tick();
    check("idle_run_no_writes", we_cnt_a - we0, 0);

    // Abort while the second sample's byte is on the wire.
    busy_len[0] = 6;
    base = start_cnt_a;
    exp_a.push_back(8'h25); exp_a.push_back(8'h24);
    acq(0, 8'h21, 6, 3, 2, 4);
    wait_starts(base + 2);
    repeat (2) tick();
    abort_p[0] = 1'b1;
    tick();
    abort_p[0] = 1'b0;
    check("abort_busy", int'(busy[0]), 0);
    check("abort_tx_start", int'(bus_a.tx_start), 0);
    repeat (60) tick();
    check("abort_no_more_starts", start_cnt_a - base, 2);
    check("abort_bytes_left", exp_a.size(), 0);

    // Asynchronous reset at the same point.
    base = start_cnt_a;
    exp_a.push_back(8'h35); exp_a.push_back(8'h34);
    acq(0, 8'h31, 6, 3, 2, 4);
    wait_starts(base + 2);
    repeat (2) tick();
    reset_n = 1'b0;
    #1;
    check("areset_busy",     int'(busy[0]), 0);
    check("areset_tx_start", int'(bus_a.tx_start), 0);
    check("areset_tx_byte",  int'(bus_a.tx_byte), 0);
    check("areset_mem_re",   int'(bus_a.mem_re), 0);
    check("areset_done",     int'(done[0]), 0);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (60) tick();
    check("areset_no_more_starts", start_cnt_a - base, 2);
    check("areset_busy_after", int'(busy[0]), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
